// File: rtl/lcd_pkg.sv
// lcd_pkg: shared scan-state type, window constants and pixel index helpers for lcd_scan_sink
package lcd_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} scan_state_t;

  localparam int WIN  = 4;
  localparam int NPIX = 16;
  localparam logic [3:0] LAST_IDX = 4'(NPIX - 1);

  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    return 2'(idx / 4'(WIN));
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    return 2'(idx % 4'(WIN));
  endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// lcd_frame_buf: two banks of 16 pixels, one write port and one async read port
module lcd_frame_buf
  import lcd_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [3:0]       waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rbank,
  input  logic [3:0]       raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [2][NPIX];

  // write the captured pixel into the capture bank; contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem_q[wbank][waddr] <= wdata;
  end

  assign rdata = mem_q[rbank][raddr];

endmodule

// File: rtl/lcd_scan_sink.sv
// lcd_scan_sink: double-buffered 4x4 window capture and paced raster replay to the panel (LCD_SCAN_SINK_DROP_CNT_EN enables drop_cnt)
module lcd_scan_sink
  import lcd_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int WR_GAP = 2,
  parameter int DCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic [PIX_W-1:0]  px_data,
  output logic [1:0]        px_row,
  output logic [1:0]        px_col,
  output logic              px_we,
  output logic              scan_busy,
  output logic              frame_done,
  output logic [DCNT_W-1:0] drop_cnt
);

  localparam logic [3:0] GAP_LAST = 4'(WR_GAP > 0 ? WR_GAP - 1 : 0);

  scan_state_t state_q, state_d;
  logic [3:0] cap_cnt_q, cap_cnt_d, idx_q, idx_d, gap_q, gap_d;
  logic pending_q, pending_d, bank_q, bank_d, drop_q, drop_d;
  logic swap, pend_eff, discard, beat_last, wr_en, show;
  logic [PIX_W-1:0] rd_data;

  // admission is latched on beat 0; a swap in the same edge frees the capture bank for beat 0
  always_comb begin
    swap      = pending_q && state_q == IDLE;
    pend_eff  = pending_q && !swap;
    discard   = cap_cnt_q == 4'd0 ? pend_eff : drop_q;
    beat_last = pix_valid && cap_cnt_q == LAST_IDX;
    wr_en     = pix_valid && !discard;
    cap_cnt_d = pix_valid ? cap_cnt_q + 4'd1 : cap_cnt_q;
    drop_d    = pix_valid ? discard : drop_q;
    pending_d = pend_eff || (beat_last && !discard);
    bank_d    = swap ? ~bank_q : bank_q;
  end

  // state register for capture control and scan FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      cap_cnt_q <= '0;
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      cap_cnt_q <= cap_cnt_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
      drop_q    <= drop_d;
    end
  end

  // scan sequencing: one write per pixel followed by WR_GAP recovery cycles
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (swap) begin
        state_d = WRITE;
        idx_d   = '0;
        gap_d   = '0;
      end
      WRITE: if (WR_GAP > 0) begin
        state_d = GAP;
        gap_d   = '0;
      end else if (idx_q == LAST_IDX) state_d = DONE;
      else idx_d = idx_q + 4'd1;
      GAP: if (gap_q != GAP_LAST) gap_d = gap_q + 4'd1;
      else if (idx_q == LAST_IDX) state_d = DONE;
      else begin
        state_d = WRITE;
        idx_d   = idx_q + 4'd1;
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // panel outputs: address/data held through the gap, zero when not scanning
  always_comb begin
    show       = state_q == WRITE || state_q == GAP;
    px_we      = state_q == WRITE;
    px_data    = show ? rd_data : '0;
    px_row     = show ? idx_row(idx_q) : 2'd0;
    px_col     = show ? idx_col(idx_q) : 2'd0;
    scan_busy  = state_q != IDLE;
    frame_done = state_q == DONE;
  end

  lcd_frame_buf #(.PIX_W(PIX_W)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .wbank (~bank_d),
    .waddr (cap_cnt_q),
    .wdata (pix_in),
    .rbank (bank_q),
    .raddr (idx_q),
    .rdata (rd_data)
  );

`ifdef LCD_SCAN_SINK_DROP_CNT_EN
  logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // count discarded frames on their last beat, saturating
  always_comb begin
    drop_cnt_d = beat_last && discard && drop_cnt_q != '1 ? drop_cnt_q + DCNT_W'(1) : drop_cnt_q;
  end

  // drop counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
